// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with prescaled stepping and a time-multiplexed
// active-low 7-segment drive. Define BCD_LZ_BLANK_EN to blank leading zero digits.
module bcd_counter_display #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 20_000_000,
    parameter int unsigned SCAN_DIV = 12_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CW = 4 * DIGITS;

    logic [PW-1:0] presc;
    logic [SW-1:0] scnt;
    logic [IW-1:0] idx;
    logic          tick;
    logic [CW-1:0] step_count;
    logic [CW-1:0] load_clean;
    logic          carry;
    logic [3:0]    d;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    enc = 7'b0000001;
            4'd1:    enc = 7'b1001111;
            4'd2:    enc = 7'b0010010;
            4'd3:    enc = 7'b0000110;
            4'd4:    enc = 7'b1001100;
            4'd5:    enc = 7'b0100100;
            4'd6:    enc = 7'b0100000;
            4'd7:    enc = 7'b0001111;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0000100;
            default: enc = 7'b1111111;
        endcase
    endfunction

    assign tick = en && (presc == PW'(TICK_DIV - 1));

    // Ripple carry/borrow across digits; carry surviving the top digit means full wrap.
    always_comb begin
        step_count = count;
        carry      = 1'b1;
        d          = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = count[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (d == 4'd9) step_count[4*i +: 4] = 4'd0;
                    else begin
                        step_count[4*i +: 4] = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) step_count[4*i +: 4] = 4'd9;
                    else begin
                        step_count[4*i +: 4] = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // Non-decimal load nibbles are forced to 0 so count digits stay in 0..9.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            presc <= '0;
            count <= load_clean;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (tick) begin
                presc <= '0;
                count <= step_count;
                tc    <= carry;
            end else if (en) begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            idx  <= '0;
        end else if (scnt == SW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            scnt <= scnt + SW'(1);
        end
    end

`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              hz;

    // A digit blanks when it and every more significant digit are zero.
    always_comb begin
        blank = '0;
        hz    = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            hz       = hz && (count[4*i +: 4] == 4'd0);
            blank[i] = hz;
        end
    end
`endif

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx) begin
                cur_digit = count[4*i +: 4];
`ifdef BCD_LZ_BLANK_EN
                cur_blank = blank[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= 7'b1111111;
            dig_sel <= '1;
        end else begin
            seg     <= cur_blank ? 7'b1111111 : enc(cur_digit);
            dig_sel <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_counter_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_counter_display #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        step(1);
        load     = 1'b0;
    endtask

    logic [1:0] v, other, exp_sel;
    logic [6:0] lz_exp;
    bit         found;

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        step(2);
        check("rst_count", 32'(count), 32'h00);
        check("rst_seg", 32'(seg), 32'h7f);
        check("rst_dig_sel", 32'(dig_sel), 32'h3);
        rst_n = 1'b1;
        step(1);

        // 1: async reset from 0x37
        do_load(8'h37);
        check("load_37", 32'(count), 32'h37);
        step(1);
        check("disp_active", 32'(dig_sel == 2'b11), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'h00);
        check("async_tc", 32'(tc), 32'h0);
        check("async_seg", 32'(seg), 32'h7f);
        check("async_dig_sel", 32'(dig_sel), 32'h3);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 2: count up
        en = 1'b1; up = 1'b1;
        step(40);
        check("up_40clk", 32'(count), 32'h10);
        check("up_tc_low", 32'(tc), 32'h0);
        step(89 * 4);
        check("up_99", 32'(count), 32'h99);
        check("up_99_tc", 32'(tc), 32'h0);
        step(4);
        check("up_wrap", 32'(count), 32'h00);
        check("up_wrap_tc", 32'(tc), 32'h1);
        step(1);
        check("up_tc_pulse", 32'(tc), 32'h0);

        // 3: count down through wrap, then freeze
        up = 1'b0;
        do_load(8'h00);
        step(3);
        check("dn_pre", 32'(count), 32'h00);
        step(1);
        check("dn_wrap", 32'(count), 32'h99);
        check("dn_wrap_tc", 32'(tc), 32'h1);
        step(1);
        check("dn_tc_pulse", 32'(tc), 32'h0);
        en = 1'b0;
        step(20);
        check("en_hold", 32'(count), 32'h99);
        check("en_hold_tc", 32'(tc), 32'h0);

        // 4: load beats tick; would otherwise wrap 0x99 up with tc
        en = 1'b1; up = 1'b1;
        do_load(8'h99);
        step(3);
        load_val = 8'h5A; load = 1'b1;
        step(1);
        load = 1'b0;
        check("ld_tick_count", 32'(count), 32'h50);
        check("ld_tick_tc", 32'(tc), 32'h0);
        step(3);
        check("ld_presc_cleared", 32'(count), 32'h50);
        step(1);
        check("ld_next_tick", 32'(count), 32'h51);

        // reset mid-interval discards partial prescale
        step(2);
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(3);
        check("rst_mid_pre", 32'(count), 32'h00);
        step(1);
        check("rst_mid_tick", 32'(count), 32'h01);

        // 5: scan of 0x42
        en = 1'b0;
        do_load(8'h42);
        step(2);
        v = dig_sel;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            step(1);
            if (dig_sel != v) found = 1'b1;
        end
        check("scan_change", 32'(found), 32'h1);
        v = dig_sel;
        check("scan_onehot", 32'(v == 2'b10 || v == 2'b01), 32'h1);
        other = (v == 2'b10) ? 2'b01 : 2'b10;
        for (int k = 0; k < 8; k++) begin
            exp_sel = (((k / 2) % 2) == 0) ? v : other;
            check("scan_sel", 32'(dig_sel), 32'(exp_sel));
            check("scan_seg", 32'(seg), (exp_sel == 2'b10) ? 32'h12 : 32'h4c);
            step(1);
        end

        // 6: leading-zero digit of 0x07
        do_load(8'h07);
        step(2);
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            if (dig_sel == 2'b01) found = 1'b1;
            else step(1);
        end
        check("lz_found", 32'(found), 32'h1);
`ifdef BCD_LZ_BLANK_EN
        lz_exp = 7'b1111111;
`else
        lz_exp = 7'b0000001;
`endif
        check("lz_digit1", 32'(seg), 32'(lz_exp));
        step(2);
        check("lz_digit0_sel", 32'(dig_sel), 32'h2);
        check("lz_digit0", 32'(seg), 32'h0f);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
